// File: rtl/mioc.sv
// Memory/IO controller behind the write-back stage: decodes each access into a
// variable-latency data RAM or memory-mapped IO (LEDs, buttons, 7-segment display).
module mioc #(
   parameter int RAM_AW  = 10,
   parameter int TIMEOUT = 16,
   parameter int BTN_W   = 4,
   parameter int LED_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mr,
   input  logic              mw,
   input  logic              io_r,
   input  logic              io_w,
   input  logic [31:0]       m_iaddr,
   input  logic [31:0]       wm_idata,
   output logic [31:0]       rm_idata,
   output logic              stall,
   output logic              err,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic              ram_req,
   output logic              ram_we,
   input  logic              ram_ready,
   input  logic [31:0]       ram_rdata,
   input  logic [BTN_W-1:0]  btn,
   output logic [LED_W-1:0]  led,
   output logic [31:0]       seg,
   output logic [1:0]        dbg_state
);

   localparam logic [31:0] LED_ADDR = 32'hFFFF_FF00;
   localparam logic [31:0] BTN_ADDR = 32'hFFFF_FF04;
   localparam logic [31:0] SEG_ADDR = 32'hFFFF_FF08;
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RAM_WAIT = 2'd1,
      DONE     = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [31:0]         rd_q, rd_d;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [RAM_AW-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [LED_W-1:0]    led_q, led_d;
   logic [31:0]         seg_q, seg_d;
   logic [BTN_W-1:0]    btn_meta_q, btn_sync_q;

   logic        access, is_rd, is_wr, both;
   logic        ram_hit, led_hit, btn_hit, seg_hit, fault;
   logic [31:0] io_rdata;
   logic        stall_c, err_c;
   logic        unused_io_qual;

   // io_r/io_w are informational only; decode is purely address-based.
   assign unused_io_qual = ^{io_r, io_w};

   assign access  = mr | mw;
   assign is_rd   = mr;
   assign is_wr   = mw & ~mr;
   assign both    = mr & mw;

   assign ram_hit = (m_iaddr[31:RAM_AW+2] == '0) && (m_iaddr[1:0] == 2'b00);
   assign led_hit = (m_iaddr == LED_ADDR);
   assign btn_hit = (m_iaddr == BTN_ADDR);
   assign seg_hit = (m_iaddr == SEG_ADDR);
   assign fault   = access & ~(ram_hit | led_hit | btn_hit | seg_hit);

   always_comb begin
      io_rdata = '0;
      if (led_hit)      io_rdata = 32'(led_q);
      else if (btn_hit) io_rdata = 32'(btn_sync_q);
      else if (seg_hit) io_rdata = seg_q;
   end

   // RAM handshake: ram_req rises with ram_we/ram_addr/ram_wdata and all four
   // stay stable until the cycle ram_ready=1; that cycle completes the access
   // (read data sampled there) and ram_req is low from the next cycle on.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      led_d   = led_q;
      seg_d   = seg_q;
      stall_c = 1'b0;
      err_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (fault) begin
                  err_c = 1'b1;
                  rd_d  = '0;
               end else if (ram_hit) begin
                  stall_c = 1'b1;
                  err_c   = both;
                  req_d   = 1'b1;
                  we_d    = is_wr;
                  addr_d  = m_iaddr[RAM_AW+1:2];
                  wdata_d = wm_idata;
                  cnt_d   = '0;
                  state_d = RAM_WAIT;
               end else begin
                  // Simultaneous mr/mw resolves to a read; the write is dropped.
                  err_c = both | (is_wr & btn_hit);
                  if (is_rd)        rd_d  = io_rdata;
                  else if (led_hit) led_d = wm_idata[LED_W-1:0];
                  else if (seg_hit) seg_d = wm_idata;
               end
            end
         end
         RAM_WAIT: begin
            stall_c = 1'b1;
            if (ram_ready) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               if (!we_q) rd_d = ram_rdata;
               state_d = DONE;
            end else if (cnt_q == CNT_MAX) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               rd_d    = TIMEOUT_DATA;
               err_c   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         // The request is still asserted upstream here; it must not re-issue.
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rd_q       <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         led_q      <= '0;
         seg_q      <= '0;
         btn_meta_q <= '0;
         btn_sync_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         led_q      <= led_d;
         seg_q      <= seg_d;
         btn_meta_q <= btn;
         btn_sync_q <= btn_meta_q;
      end
   end

   // In IDLE the load value is combinational; otherwise the read register holds.
   assign rm_idata  = !rst ? '0 : ((state_q == IDLE) ? rd_d : rd_q);
   assign stall     = stall_c & rst;
   assign err       = err_c & rst;
   assign ram_req   = req_q;
   assign ram_we    = we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign led       = led_q;
   assign seg       = seg_q;
   assign dbg_state = state_q;

endmodule
